var_len_deserializer: RTL and testbench

// Serial-to-parallel converter with run-time word length and compile-time bit order.

---
 rtl/var_len_deserializer.sv | 207 ++++++++++++++++++++
 tb/tb_var_len_deserializer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_len_deserializer.sv
// var_len_deserializer
//   Serial-to-parallel converter with a run-time frame length (1..WIDTH) and a
//   compile-time bit order. Accepted bits (data_val_i=1) are collected into a
//   WIDTH-bit register. Each completed frame is emitted right-justified, with
//   the unused upper bits at 0, together with a one-cycle valid pulse.
//
// Optional feature (macro DESER_PARITY_CHECK_EN):
//   Each frame is followed by one even-parity bit. The word is issued after the
//   parity bit, and deser_par_err_o flags a mismatch alongside the valid pulse.
//
// Parameters
//   WIDTH      maximum word length in bits (>= 2)
//   MSB_FIRST  1: first received bit is the word MSB; 0: first bit is bit 0
//   LEN_W      width of data_len_i (derived)
//
// Ports
//   clk_i             clock
//   srst_i            asynchronous active-high reset
//   data_i            serial data bit
//   data_val_i        qualifier for data_i
//   data_len_i        frame length, sampled with the first bit (0 or >WIDTH -> WIDTH)
//   flush_i           abort a partial frame; the bit in the same cycle is dropped
//   deser_data_o      assembled word, held until the next completion
//   deser_data_val_o  one-cycle pulse per frame
//   deser_busy_o      1 while a frame is partially received
//   deser_par_err_o   parity mismatch, valid with deser_data_val_o (parity build only)

module var_len_deserializer #(
    parameter int  WIDTH     = 16,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int LEN_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             data_i,
    input  logic             data_val_i,
    input  logic [LEN_W-1:0] data_len_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic             deser_data_val_o,
    output logic             deser_busy_o
`ifdef DESER_PARITY_CHECK_EN
    ,
    output logic             deser_par_err_o
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StShift
`ifdef DESER_PARITY_CHECK_EN
        ,
        StParity
`endif
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_val;
    logic             r_busy;
`ifdef DESER_PARITY_CHECK_EN
    logic             r_par;      // running XOR of the data bits of this frame
    logic             r_par_err;
`endif

    logic [LEN_W-1:0] w_len_clamped;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_first;    // register image after the first bit of a frame
    logic [WIDTH-1:0] w_word;     // register image after the current bit in SHIFT

    always_comb begin
        w_len_clamped = data_len_i;
        if (data_len_i == '0 || data_len_i > LEN_W'(WIDTH)) begin
            w_len_clamped = LEN_W'(WIDTH);
        end

        w_cnt_inc = r_cnt + LEN_W'(1);

        // The first bit lands in bit 0 for both orders: MSB-first shifts it up later.
        w_first    = '0;
        w_first[0] = data_i;

        w_word = r_shreg;
        if (MSB_FIRST) begin
            w_word = {r_shreg[WIDTH-2:0], data_i};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_cnt == LEN_W'(i)) begin
                    w_word[i] = data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_len     <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_val     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
`endif
        end else begin
            r_val <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
            r_par_err <= 1'b0;
`endif
            if (flush_i) begin
                // Flush wins over any bit presented in the same cycle.
                r_state <= StIdle;
                r_cnt   <= '0;
                r_shreg <= '0;
                r_busy  <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
                r_par   <= 1'b0;
`endif
            end else if (data_val_i) begin
                case (r_state)
                    StIdle: begin
                        r_len <= w_len_clamped;
                        r_cnt <= LEN_W'(1);
`ifdef DESER_PARITY_CHECK_EN
                        r_par   <= data_i;
                        r_shreg <= w_first;
                        r_busy  <= 1'b1;
                        if (w_len_clamped == LEN_W'(1)) begin
                            r_state <= StParity;
                        end else begin
                            r_state <= StShift;
                        end
`else
                        if (w_len_clamped == LEN_W'(1)) begin
                            r_data  <= w_first;
                            r_val   <= 1'b1;
                            r_cnt   <= '0;
                            r_shreg <= '0;
                        end else begin
                            r_shreg <= w_first;
                            r_state <= StShift;
                            r_busy  <= 1'b1;
                        end
`endif
                    end

                    StShift: begin
                        r_cnt <= w_cnt_inc;
`ifdef DESER_PARITY_CHECK_EN
                        r_par   <= r_par ^ data_i;
                        r_shreg <= w_word;
                        if (w_cnt_inc == r_len) begin
                            r_state <= StParity;
                        end
`else
                        if (w_cnt_inc == r_len) begin
                            r_data  <= w_word;
                            r_val   <= 1'b1;
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_shreg <= '0;
                        end else begin
                            r_shreg <= w_word;
                        end
`endif
                    end

`ifdef DESER_PARITY_CHECK_EN
                    StParity: begin
                        // Word is delivered even when the parity bit disagrees.
                        r_data    <= r_shreg;
                        r_val     <= 1'b1;
                        r_par_err <= r_par ^ data_i;
                        r_state   <= StIdle;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_shreg   <= '0;
                        r_par     <= 1'b0;
                    end
`endif

                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end
                endcase
            end
        end
    end

    assign deser_data_o     = r_data;
    assign deser_data_val_o = r_val;
    assign deser_busy_o     = r_busy;
`ifdef DESER_PARITY_CHECK_EN
    assign deser_par_err_o  = r_par_err;
`endif

endmodule

// File: tb/tb_var_len_deserializer.sv
// Bench for var_len_deserializer: one MSB-first and one LSB-first instance share
// the same stimulus. Expected words are queued when frames are driven and compared
// against words captured on each valid pulse.

module tb_var_len_deserializer;

    localparam int WIDTH = 16;
    localparam int LEN_W = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             srst;
    logic             din;
    logic             dval;
    logic [LEN_W-1:0] dlen;
    logic             flush;

    logic [WIDTH-1:0] data_m, data_l;
    logic             val_m, val_l, busy_m, busy_l;
    logic             err_m, err_l;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_m[$], exp_l[$], obs_m[$], obs_l[$];
    logic             exp_e[$], obs_e[$];
    time              obs_t[$];

    always #5 clk = ~clk;

    var_len_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk_i            (clk),
        .srst_i           (srst),
        .data_i           (din),
        .data_val_i       (dval),
        .data_len_i       (dlen),
        .flush_i          (flush),
        .deser_data_o     (data_m),
        .deser_data_val_o (val_m),
        .deser_busy_o     (busy_m)
`ifdef DESER_PARITY_CHECK_EN
        ,
        .deser_par_err_o  (err_m)
`endif
    );

    var_len_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i            (clk),
        .srst_i           (srst),
        .data_i           (din),
        .data_val_i       (dval),
        .data_len_i       (dlen),
        .flush_i          (flush),
        .deser_data_o     (data_l),
        .deser_data_val_o (val_l),
        .deser_busy_o     (busy_l)
`ifdef DESER_PARITY_CHECK_EN
        ,
        .deser_par_err_o  (err_l)
`endif
    );

`ifndef DESER_PARITY_CHECK_EN
    assign err_m = 1'b0;
    assign err_l = 1'b0;
`endif

    // Capture every pulse away from the active edge.
    always @(negedge clk) begin
        if (val_m) begin
            obs_m.push_back(data_m);
            obs_e.push_back(err_m);
            obs_t.push_back($time);
        end
        if (val_l) obs_l.push_back(data_l);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dval = 1'b0;
        repeat (n) tick();
    endtask

    // Drives n bits of word, MSB of the n-bit value first. push=0 sends a partial
    // frame (no parity bit, nothing expected). busy_low counts mid-frame cycles
    // where the MSB-first instance did not report busy.
    task automatic send_frame(input logic [WIDTH-1:0] word, input int n,
                              input logic [LEN_W-1:0] len_in, input bit gaps,
                              input bit bad_par, input bit push, output int busy_low);
        logic [WIDTH-1:0] em, el;
        logic             p;
        em = '0;
        el = '0;
        p = 1'b0;
        busy_low = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                dval = 1'b0;
                din  = ~din;
                tick();
                if (busy_m !== 1'b1) busy_low++;
            end
            din  = word[n-1-i];
            dval = 1'b1;
            dlen = (i == 0) ? len_in : LEN_W'($urandom_range(0, 31));
            em[n-1-i] = din;
            el[i]     = din;
            p         = p ^ din;
            tick();
            if (i < n - 1 && busy_m !== 1'b1) busy_low++;
        end
        if (push && PAR == 1) begin
            din  = p ^ bad_par;
            dval = 1'b1;
            dlen = LEN_W'($urandom_range(0, 31));
            tick();
        end
        if (push) begin
            exp_m.push_back(em);
            exp_l.push_back(el);
            exp_e.push_back(bad_par);
        end
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (obs_m.size() >= n && obs_l.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_queues();
        exp_m.delete(); exp_l.delete(); exp_e.delete();
        obs_m.delete(); obs_l.delete(); obs_e.delete(); obs_t.delete();
    endtask

    task automatic test_reset();
        srst = 1'b1; din = 1'b0; dval = 1'b1; dlen = '0; flush = 1'b0;
        repeat (3) tick();
        checks++;
        if (data_m !== '0 || data_l !== '0 || val_m !== 1'b0 || val_l !== 1'b0 ||
            busy_m !== 1'b0 || busy_l !== 1'b0 || err_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h/%h val=%b/%b busy=%b/%b err=%b required all 0",
                     data_m, data_l, val_m, val_l, busy_m, busy_l, err_m);
        end
        dval = 1'b0;
        srst = 1'b0;
        idle(2);
        clear_queues();
    endtask

    task automatic test_basic();
        int bl;
        bit ok;
        send_frame(16'hA5C3, 16, LEN_W'(16), 1'b0, 1'b0, 1'b1, bl);
        dval = 1'b0;
        checks++;
        if (val_m !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse_latency: got val=%b required 1", val_m);
        end
        tick();
        checks++;
        if (val_m !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: got val=%b required 0", val_m);
        end
        wait_obs(exp_m.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_pulses: got %0d words required %0d", obs_m.size(), exp_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL basic_word_lsb: got %h required %h", o, e); end
        end
        checks++;
        if (data_m !== 16'hA5C3) begin
            errors++;
            $display("FAIL basic_hold: got %h required a5c3", data_m);
        end
        clear_queues();
    endtask

    task automatic test_short_len();
        int bl;
        bit ok;
        send_frame(16'h0016, 5, LEN_W'(5), 1'b0, 1'b0, 1'b1, bl);
        idle(1);
        send_frame(16'h0001, 1, LEN_W'(1), 1'b0, 1'b0, 1'b1, bl);
        idle(1);
        wait_obs(exp_m.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL short_pulses: got %0d words required %0d", obs_m.size(), exp_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL short_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL short_word_lsb: got %h required %h", o, e); end
        end
        clear_queues();
    endtask

    task automatic test_clamp();
        int bl;
        bit ok;
        send_frame(16'hFFFF, 16, LEN_W'(0), 1'b0, 1'b0, 1'b1, bl);
        idle(2);
        checks++;
        if (busy_m !== 1'b0) begin
            errors++;
            $display("FAIL clamp_len0_busy: got %b required 0", busy_m);
        end
        send_frame(16'hFFFF, 16, LEN_W'(20), 1'b0, 1'b0, 1'b1, bl);
        idle(2);
        checks++;
        if (busy_m !== 1'b0) begin
            errors++;
            $display("FAIL clamp_len20_busy: got %b required 0", busy_m);
        end
        wait_obs(exp_m.size(), ok);
        checks++;
        if (!ok || obs_m.size() != 2) begin
            errors++;
            $display("FAIL clamp_pulses: got %0d words required 2", obs_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL clamp_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL clamp_word_lsb: got %h required %h", o, e); end
        end
        clear_queues();
    endtask

    task automatic test_gaps();
        int bl;
        bit ok;
        send_frame(16'h1234, 16, LEN_W'(16), 1'b1, 1'b0, 1'b1, bl);
        dval = 1'b0;
        checks++;
        if (bl != 0) begin
            errors++;
            $display("FAIL gaps_busy: got %0d low cycles required 0", bl);
        end
        wait_obs(exp_m.size(), ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL gaps_pulses: got %0d words required %0d", obs_m.size(), exp_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL gaps_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL gaps_word_lsb: got %h required %h", o, e); end
        end
        clear_queues();
    endtask

    task automatic test_flush_reset();
        int bl;
        bit ok;
        send_frame(16'h0055, 7, LEN_W'(12), 1'b0, 1'b0, 1'b0, bl);
        flush = 1'b1; dval = 1'b1; din = 1'b1;
        tick();
        flush = 1'b0; dval = 1'b0;
        checks++;
        if (busy_m !== 1'b0 || val_m !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got busy=%b val=%b required 0/0", busy_m, val_m);
        end
        send_frame(16'h003C, 8, LEN_W'(8), 1'b0, 1'b0, 1'b1, bl);
        idle(6);
        checks++;
        if (obs_m.size() != 1) begin
            errors++;
            $display("FAIL flush_pulse_count: got %0d required 1", obs_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL flush_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL flush_word_lsb: got %h required %h", o, e); end
        end
        clear_queues();

        // Asynchronous reset in the middle of a frame.
        send_frame(16'h0015, 5, LEN_W'(16), 1'b0, 1'b0, 1'b0, bl);
        #2 srst = 1'b1;
        #1;
        checks++;
        if (data_m !== '0 || val_m !== 1'b0 || busy_m !== 1'b0 || busy_l !== 1'b0) begin
            errors++;
            $display("FAIL srst_async: got data=%h val=%b busy=%b required 0/0/0", data_m, val_m,
                     busy_m);
        end
        dval = 1'b0;
        tick();
        srst = 1'b0;
        idle(4);
        send_frame(16'h0005, 3, LEN_W'(3), 1'b0, 1'b0, 1'b1, bl);
        idle(4);
        checks++;
        if (obs_m.size() != 1) begin
            errors++;
            $display("FAIL srst_pulse_count: got %0d required 1", obs_m.size());
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL srst_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL srst_word_lsb: got %h required %h", o, e); end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        int  bl;
        bit  ok;
        time t0, t1, t2;
        send_frame(16'h000A, 4, LEN_W'(4), 1'b0, 1'b0, 1'b1, bl);
        send_frame(16'h0005, 4, LEN_W'(4), 1'b0, 1'b1, 1'b1, bl);
        send_frame(16'h000F, 4, LEN_W'(4), 1'b0, 1'b0, 1'b1, bl);
        dval = 1'b0;
        wait_obs(exp_m.size(), ok);
        idle(3);
        checks++;
        if (!ok || obs_m.size() != 3) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d words required 3", obs_m.size());
        end else begin
            t0 = obs_t[0]; t1 = obs_t[1]; t2 = obs_t[2];
            checks++;
            if ((t1 - t0) != (4 + PAR) * 10 || (t2 - t1) != (4 + PAR) * 10) begin
                errors++;
                $display("FAIL b2b_spacing: got %0t/%0t required %0d", t1 - t0, t2 - t1,
                         (4 + PAR) * 10);
            end
        end
        while (exp_m.size() > 0 && obs_m.size() > 0 && obs_l.size() > 0) begin
            logic [WIDTH-1:0] e, o;
            logic             ee, oe;
            e = exp_m.pop_front(); o = obs_m.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_word_msb: got %h required %h", o, e); end
            e = exp_l.pop_front(); o = obs_l.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_word_lsb: got %h required %h", o, e); end
            ee = exp_e.pop_front(); oe = obs_e.pop_front();
            if (PAR == 1) begin
                checks++;
                if (oe !== ee) begin
                    errors++;
                    $display("FAIL b2b_par_err: got %b required %b", oe, ee);
                end
            end
        end
        clear_queues();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_short_len();
        test_clamp();
        test_gaps();
        test_flush_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
